// File: rtl/snn_pkg.sv
// Shared types and constants for the spiking-layer datapath blocks.
package snn_pkg;

  localparam int ID_W      = 4;
  localparam int N_NEURONS = 2 ** ID_W;

  typedef logic [ID_W-1:0] neuron_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } enc_state_t;

  // Unsigned 8-bit add that clamps at 255 instead of wrapping.
  function automatic logic [7:0] sat_add_u8(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] sum;
    sum = {1'b0, a} + {4'b0000, b};
    return sum[8] ? 8'hFF : sum[7:0];
  endfunction

endpackage

// File: rtl/spike_encoder_if.sv
// Spike-encoder bundle: spike/step inputs and the FIFO write side.
// The drop_cnt signal exists only when SPIKE_DROP_CNT_EN is defined.
interface spike_encoder_if
  import snn_pkg::*;
#(
  parameter int N_NEURONS = snn_pkg::N_NEURONS,
  parameter int ID_W      = snn_pkg::ID_W
);
  logic [N_NEURONS-1:0] spike_in;
  logic                 step_end;
  logic                 fifo_full;
  logic                 clr_ovf;
  logic                 wen;
  logic [ID_W-1:0]      dout;
  logic                 done;
  logic                 busy;
  logic                 overflow;
  enc_state_t           state;
`ifdef SPIKE_DROP_CNT_EN
  logic [7:0]           drop_cnt;
`endif

  // Handshake: dout is meaningful only in a cycle with wen=1; the encoder never
  // raises wen in the cycle after fifo_full was seen high, so wen is a write
  // the FIFO must accept (fifo_full acts as ready, sampled in the grant cycle).
  modport master (
    input  spike_in, step_end, fifo_full, clr_ovf,
    output wen, dout, done, busy, overflow, state
`ifdef SPIKE_DROP_CNT_EN
    , output drop_cnt
`endif
  );

  modport slave (
    output spike_in, step_end, fifo_full, clr_ovf,
    input  wen, dout, done, busy, overflow, state
`ifdef SPIKE_DROP_CNT_EN
    , input drop_cnt
`endif
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr,
// wrapping modulo N. N must equal 2**W so the index wrap is free.
module rr_arbiter
  import snn_pkg::*;
#(
  parameter int N = snn_pkg::N_NEURONS,
  parameter int W = snn_pkg::ID_W
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] gnt_id,
  output logic         gnt_valid
);

  logic [W-1:0] idx;

  always_comb begin
    gnt_onehot = '0;
    gnt_id     = '0;
    gnt_valid  = 1'b0;
    idx        = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + W'(i);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = idx;
      end
    end
    if (gnt_valid) gnt_onehot = N'(1) << gnt_id;
  end

endmodule

// File: rtl/spike_encoder.sv
// Collects spike pulses into a pending set and serialises them as neuron IDs
// to the event FIFO, round-robin. Optional drop counter: SPIKE_DROP_CNT_EN.
module spike_encoder
  import snn_pkg::*;
#(
  parameter int N_NEURONS = snn_pkg::N_NEURONS,
  parameter int ID_W      = snn_pkg::ID_W
) (
  input logic            clock,
  input logic            reset,
  spike_encoder_if.master bus
);

  logic [N_NEURONS-1:0] pending_q, pending_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      dout_q, dout_d;
  enc_state_t           state_q, state_d;
  logic                 wen_q, wen_d;
  logic                 done_q, done_d;
  logic                 overflow_q, overflow_d;

  logic [N_NEURONS-1:0] arb_onehot, gnt_mask, ovf_hits;
  logic [ID_W-1:0]      arb_id;
  logic                 arb_valid, grant;

  rr_arbiter #(.N(N_NEURONS), .W(ID_W)) u_arb (
    .req        (pending_q),
    .ptr        (rr_ptr_q),
    .gnt_onehot (arb_onehot),
    .gnt_id     (arb_id),
    .gnt_valid  (arb_valid)
  );

  always_comb begin
    grant    = arb_valid && !bus.fifo_full && (state_q == ARB || state_q == DRAIN);
    gnt_mask = grant ? arb_onehot : '0;
    // A spike landing on a bit that is being granted this cycle is a fresh event, not a loss.
    ovf_hits  = bus.spike_in & pending_q & ~gnt_mask;
    pending_d = (pending_q & ~gnt_mask) | bus.spike_in;

    overflow_d = overflow_q;
    if (bus.clr_ovf) overflow_d = 1'b0;
    if (|ovf_hits)   overflow_d = 1'b1;

    rr_ptr_d = grant ? arb_id + ID_W'(1) : rr_ptr_q;
    wen_d    = grant;
    dout_d   = grant ? arb_id : dout_q;

    // IDLE looks at the next pending value so a new spike is granted on the following edge.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.step_end)          state_d = DRAIN;
        else if (|pending_d)       state_d = ARB;
      end
      ARB: begin
        if (bus.step_end)          state_d = DRAIN;
        else if (pending_d == '0)  state_d = IDLE;
      end
      DRAIN: begin
        if (pending_q == '0 && !grant) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pending_q  <= '0;
      rr_ptr_q   <= '0;
      dout_q     <= '0;
      state_q    <= IDLE;
      wen_q      <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      rr_ptr_q   <= rr_ptr_d;
      dout_q     <= dout_d;
      state_q    <= state_d;
      wen_q      <= wen_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.wen      = wen_q;
  assign bus.dout     = dout_q;
  assign bus.done     = done_q;
  assign bus.overflow = overflow_q;
  assign bus.state    = state_q;
  assign bus.busy     = (|pending_q) || (state_q != IDLE);

`ifdef SPIKE_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Clear first, then add this cycle's losses, so a same-cycle loss is still counted.
  always_comb begin
    drop_cnt_d = sat_add_u8(bus.clr_ovf ? 8'd0 : drop_cnt_q, 5'($countones(ovf_hits)));
  end

  always_ff @(posedge clock) begin
    if (reset) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_spike_encoder.sv
// Bench for spike_encoder: directed scenarios plus random traffic against a
// behavioural model. Also checks drop_cnt when SPIKE_DROP_CNT_EN is defined.
module tb_spike_encoder;
  import snn_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  spike_encoder_if bus ();

  spike_encoder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  bit [15:0]  m_pend;
  int         m_ptr, m_phase, m_dout, m_cnt;
  bit         m_wen, m_done, m_ovf;
  logic [3:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Phases: 0 idle, 1 serving, 2 draining for step end, 3 reporting done.
  task automatic model_step();
    int g, hits;
    bit [15:0] nxt;
    if (reset) begin
      m_pend = '0; m_ptr = 0; m_phase = 0; m_wen = 0; m_dout = 0;
      m_done = 0; m_ovf = 0; m_cnt = 0;
      exp_q.delete();
      return;
    end
    g = -1;
    if ((m_phase == 1 || m_phase == 2) && !bus.fifo_full)
      for (int k = 0; k < 16; k++)
        if (g < 0 && m_pend[(m_ptr + k) % 16]) g = (m_ptr + k) % 16;
    hits = 0;
    for (int i = 0; i < 16; i++)
      if (bus.spike_in[i] && m_pend[i] && i != g) hits++;
    nxt = m_pend;
    if (g >= 0) nxt[g] = 1'b0;
    nxt = nxt | bus.spike_in;
    if (bus.clr_ovf) begin m_ovf = 0; m_cnt = 0; end
    if (hits > 0) m_ovf = 1;
    m_cnt = (m_cnt + hits > 255) ? 255 : m_cnt + hits;
    m_wen = (g >= 0);
    if (g >= 0) begin
      m_dout = g;
      m_ptr  = (g + 1) % 16;
      exp_q.push_back(4'(g));
    end
    case (m_phase)
      0: if (bus.step_end) m_phase = 2; else if (nxt != 0) m_phase = 1;
      1: if (bus.step_end) m_phase = 2; else if (nxt == 0) m_phase = 0;
      2: if (m_pend == 0 && g < 0) m_phase = 3;
      default: m_phase = 0;
    endcase
    m_done = (m_phase == 3);
    m_pend = nxt;
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check("wen", 32'(bus.wen), 32'(m_wen));
    check("dout", 32'(bus.dout), 32'(m_dout));
    check("done", 32'(bus.done), 32'(m_done));
    check("busy", 32'(bus.busy), 32'((m_pend != 0) || (m_phase != 0)));
    check("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef SPIKE_DROP_CNT_EN
    check("drop_cnt", 32'(bus.drop_cnt), 32'(m_cnt));
`endif
    if (bus.wen) begin
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("sb_id", 32'(bus.dout), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic drive_idle();
    bus.spike_in  = '0;
    bus.step_end  = 1'b0;
    bus.fifo_full = 1'b0;
    bus.clr_ovf   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive_idle();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int seen9, nwen, ndone, last_wen_i, done_i;
    reset = 1'b1;
    drive_idle();
    @(negedge clock);
    tick();
    tick();
    reset = 1'b0;
    check("rst_wen", 32'(bus.wen), 32'd0);
    check("rst_dout", 32'(bus.dout), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(bus.state), 32'(IDLE));

    // Single spike: two edges to wen
    bus.spike_in = 16'h0001;
    tick();
    bus.spike_in = '0;
    tick();
    check("single_wen", 32'(bus.wen), 32'd1);
    check("single_dout", 32'(bus.dout), 32'd0);
    check("single_busy", 32'(bus.busy), 32'd0);
    tick();
    check("single_nodone", 32'(bus.done), 32'd0);

    // Full burst from pointer 0
    do_reset();
    bus.spike_in = 16'hFFFF;
    tick();
    bus.spike_in = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("burst0_id", 32'(bus.dout), 32'(i));
      check("burst0_wen", 32'(bus.wen), 32'd1);
    end
    tick();
    // Move pointer to 5, then full burst again
    bus.spike_in = 16'h0010;
    tick();
    bus.spike_in = '0;
    tick();
    check("ptr5_prep", 32'(bus.dout), 32'd4);
    bus.spike_in = 16'hFFFF;
    tick();
    bus.spike_in = '0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("burst5_id", 32'(bus.dout), 32'((5 + i) % 16));
    end
    tick();

    // Neuron 3 firing continuously must not starve neuron 9
    do_reset();
    seen9 = 0;
    for (int i = 0; i < 10; i++) begin
      bus.spike_in = (i == 2) ? 16'h0208 : 16'h0008;
      tick();
      if (bus.wen && bus.dout == 4'd9) seen9 = 1;
    end
    bus.spike_in = '0;
    check("no_starve", 32'(seen9), 32'd1);
    tick(); tick();

    // Backpressure hold and release
    do_reset();
    bus.fifo_full = 1'b1;
    bus.spike_in  = 16'h0844;
    tick();
    bus.spike_in = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("full_hold_wen", 32'(bus.wen), 32'd0);
    end
    bus.fifo_full = 1'b0;
    tick(); check("rel_id0", 32'(bus.dout), 32'd2);
    tick(); check("rel_id1", 32'(bus.dout), 32'd6);
    tick(); check("rel_id2", 32'(bus.dout), 32'd11);
    tick();

    // Overflow and clear
    do_reset();
    bus.fifo_full = 1'b1;
    bus.spike_in  = 16'h0080;
    tick();
    tick();
    bus.spike_in = '0;
    check("ovf_set", 32'(bus.overflow), 32'd1);
`ifdef SPIKE_DROP_CNT_EN
    check("ovf_cnt", 32'(bus.drop_cnt), 32'd1);
`endif
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("ovf_clr", 32'(bus.overflow), 32'd0);
`ifdef SPIKE_DROP_CNT_EN
    check("ovf_cnt_clr", 32'(bus.drop_cnt), 32'd0);
`endif
    bus.fifo_full = 1'b0;
    tick(); tick();

    // Step-end drain with four pending events
    do_reset();
    bus.spike_in = 16'h1122;
    tick();
    bus.spike_in = '0;
    bus.step_end = 1'b1;
    nwen = 0; ndone = 0; last_wen_i = -10; done_i = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      bus.step_end = 1'b0;
      if (bus.wen)  begin nwen++;  last_wen_i = i; end
      if (bus.done) begin ndone++; done_i = i; end
    end
    check("drain_wen_cnt", 32'(nwen), 32'd4);
    check("drain_done_cnt", 32'(ndone), 32'd1);
    check("drain_done_pos", 32'(done_i), 32'(last_wen_i + 1));
    check("drain_idle", 32'(bus.state), 32'(IDLE));

    // Reset in the middle of a drain
    bus.spike_in = 16'hFFFF;
    tick();
    bus.spike_in = '0;
    bus.step_end = 1'b1;
    tick();
    bus.step_end = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_rst_wen", 32'(bus.wen), 32'd0);
    check("mid_rst_dout", 32'(bus.dout), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_state", 32'(bus.state), 32'(IDLE));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.spike_in  = 16'($urandom & $urandom & $urandom);
      bus.fifo_full = ($urandom_range(0, 3) == 0);
      bus.step_end  = ($urandom_range(0, 19) == 0);
      bus.clr_ovf   = ($urandom_range(0, 29) == 0);
      reset         = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    drive_idle();
    for (int i = 0; i < 40; i++) tick();
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
